eight_bit_three_to_one_arbiter_mux_module: RTL and testbench

Merges three independent 8-bit request channels onto one registered output stream, tagging each word with the 2-bit channel select code consumed by the existing 1-to-3 demux path. Sits on the return side of the demux: three producers compete, a round-robin arbiter picks one per cycle, and the winner's byte plus its select code are presented downstream with a valid/ready handshake. This closes the loop so a demuxed fan-out can be re-merged without loss or reordering within a channel.

---
 rtl/eight_bit_three_to_one_arbiter_mux_module_pkg.sv | 41 ++++
 rtl/eight_bit_three_to_one_arbiter_mux_module_arbiter.sv | 85 ++++++++
 rtl/eight_bit_three_to_one_arbiter_mux_module.sv | 118 +++++++++++
 tb/tb_eight_bit_three_to_one_arbiter_mux_module.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/eight_bit_three_to_one_arbiter_mux_module_pkg.sv
// ---------------------------------------------------------------------------
// eight_bit_three_to_one_arbiter_mux_module_pkg
//
// Purpose : Constants and types shared by the three-to-one arbiter mux and
//           the matching one-to-three demux path.
//             - SEL_IN1/SEL_IN2/SEL_IN3 : 2-bit channel select codes
//                                         (2'd3 is never produced)
//             - ptr_t                   : round-robin priority pointer state
//             - grant_to_sel()          : one-hot grant to select code
// Config  : MUX_FIXED_PRIORITY_EN (see the top module) does not change this
//           package.
// ---------------------------------------------------------------------------
package eight_bit_three_to_one_arbiter_mux_module_pkg;

   localparam int unsigned NUM_CH = 3;

   localparam logic [1:0] SEL_IN1 = 2'd0;
   localparam logic [1:0] SEL_IN2 = 2'd1;
   localparam logic [1:0] SEL_IN3 = 2'd2;

   // Channel that currently holds the highest priority.
   typedef enum logic [1:0] {
      PTR1 = 2'd0,
      PTR2 = 2'd1,
      PTR3 = 2'd2
   } ptr_t;

   // Select code of a one-hot grant. An empty grant maps to SEL_IN1; callers
   // only use the result when a grant is actually present.
   function automatic logic [1:0] grant_to_sel(input logic [NUM_CH-1:0] grant);
      logic [1:0] code;
      code = SEL_IN1;
      unique case (grant)
         3'b010:  code = SEL_IN2;
         3'b100:  code = SEL_IN3;
         default: code = SEL_IN1;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/eight_bit_three_to_one_arbiter_mux_module_arbiter.sv
// ---------------------------------------------------------------------------
// three_way_round_robin_arbiter
//
// Purpose : Purely combinational three-way arbiter.
//           Default build: round robin starting at the channel named by ptr;
//           next_ptr names the channel after the one granted (unchanged when
//           nothing is granted).
//           MUX_FIXED_PRIORITY_EN defined: strict in1 > in2 > in3 priority,
//           the ptr/next_ptr ports do not exist.
// Ports   :
//   valid     in   [2:0]  request per channel (bit 0 = in1)
//   ptr       in   ptr_t  current highest-priority channel (round robin only)
//   grant     out  [2:0]  one-hot grant, all zero when no request
//   next_ptr  out  ptr_t  pointer to adopt if the grant turns into a transfer
// ---------------------------------------------------------------------------
module three_way_round_robin_arbiter
   import eight_bit_three_to_one_arbiter_mux_module_pkg::*;
(
   input  logic [NUM_CH-1:0] valid,
`ifndef MUX_FIXED_PRIORITY_EN
   input  ptr_t              ptr,
   output ptr_t              next_ptr,
`endif
   output logic [NUM_CH-1:0] grant
);

`ifdef MUX_FIXED_PRIORITY_EN

   always_comb begin
      grant = '0;
      if (valid[0])
         grant = 3'b001;
      else if (valid[1])
         grant = 3'b010;
      else if (valid[2])
         grant = 3'b100;
   end

`else

   // Search order rotates with the pointer: the pointed channel first, then
   // the two that follow it cyclically.
   always_comb begin
      grant = '0;
      unique case (ptr)
         PTR2: begin
            if (valid[1])
               grant = 3'b010;
            else if (valid[2])
               grant = 3'b100;
            else if (valid[0])
               grant = 3'b001;
         end
         PTR3: begin
            if (valid[2])
               grant = 3'b100;
            else if (valid[0])
               grant = 3'b001;
            else if (valid[1])
               grant = 3'b010;
         end
         default: begin
            if (valid[0])
               grant = 3'b001;
            else if (valid[1])
               grant = 3'b010;
            else if (valid[2])
               grant = 3'b100;
         end
      endcase
   end

   always_comb begin
      next_ptr = ptr;
      unique case (grant)
         3'b001:  next_ptr = PTR2;
         3'b010:  next_ptr = PTR3;
         3'b100:  next_ptr = PTR1;
         default: next_ptr = ptr;
      endcase
   end

`endif

endmodule

// File: rtl/eight_bit_three_to_one_arbiter_mux_module.sv
// ---------------------------------------------------------------------------
// eight_bit_three_to_one_arbiter_mux_module
//
// Purpose : Merges three 8-bit valid/ready request channels onto one
//           registered output stream. Each output word carries the 2-bit
//           select code of its source channel (SEL_IN1/2/3).
//           Single-entry output register; one word per cycle when the
//           downstream keeps out_ready high; no bubble on consume + load.
// Config  : MUX_FIXED_PRIORITY_EN defined -> strict in1 > in2 > in3 priority,
//           no priority pointer. Undefined (default) -> round robin.
// Ports   :
//   clk                               in   system clock, rising edge
//   reset                             in   synchronous, active high
//   in1, in2, in3                     in   [DATA_WIDTH-1:0] channel data
//   in1_valid, in2_valid, in3_valid   in   channel holds a word
//   in1_ready, in2_ready, in3_ready   out  channel word accepted this cycle
//   out                               out  [DATA_WIDTH-1:0] registered data
//   sel                               out  [1:0] source tag of out
//   out_valid                         out  out/sel hold a word
//   out_ready                         in   downstream accepts the word
// ---------------------------------------------------------------------------
module eight_bit_three_to_one_arbiter_mux_module
   import eight_bit_three_to_one_arbiter_mux_module_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] in1,
   input  logic [DATA_WIDTH-1:0] in2,
   input  logic [DATA_WIDTH-1:0] in3,
   input  logic                  in1_valid,
   input  logic                  in2_valid,
   input  logic                  in3_valid,
   output logic                  in1_ready,
   output logic                  in2_ready,
   output logic                  in3_ready,
   output logic [DATA_WIDTH-1:0] out,
   output logic [1:0]            sel,
   output logic                  out_valid,
   input  logic                  out_ready
);

   logic [NUM_CH-1:0]     valid;
   logic [NUM_CH-1:0]     grant;
   logic [NUM_CH-1:0]     ready;
   logic                  can_load;
   logic                  transfer;
   logic [DATA_WIDTH-1:0] win_data;

   assign valid = {in3_valid, in2_valid, in1_valid};

`ifdef MUX_FIXED_PRIORITY_EN

   three_way_round_robin_arbiter u_arbiter (
      .valid (valid),
      .grant (grant)
   );

`else

   ptr_t ptr;
   ptr_t next_ptr;

   three_way_round_robin_arbiter u_arbiter (
      .valid    (valid),
      .ptr      (ptr),
      .next_ptr (next_ptr),
      .grant    (grant)
   );

   // The pointer only moves on an actual transfer, so a grant stalled by
   // backpressure keeps its priority.
   always_ff @(posedge clk) begin
      if (reset)
         ptr <= PTR1;
      else if (transfer)
         ptr <= next_ptr;
   end

`endif

   // Readies are forced low during reset so nothing is accepted while the
   // output register is being cleared.
   assign can_load = ~out_valid | out_ready;
   assign ready    = reset ? '0 : (grant & {NUM_CH{can_load}});
   assign transfer = |ready;

   assign in1_ready = ready[0];
   assign in2_ready = ready[1];
   assign in3_ready = ready[2];

   always_comb begin
      win_data = in1;
      unique case (grant)
         3'b010:  win_data = in2;
         3'b100:  win_data = in3;
         default: win_data = in1;
      endcase
   end

   // Output register: load wins over consume, so a simultaneous consume and
   // load keeps out_valid high. On a plain consume only out_valid clears.
   always_ff @(posedge clk) begin
      if (reset) begin
         out       <= '0;
         sel       <= SEL_IN1;
         out_valid <= 1'b0;
      end else if (transfer) begin
         out       <= win_data;
         sel       <= grant_to_sel(grant);
         out_valid <= 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_eight_bit_three_to_one_arbiter_mux_module.sv
// ---------------------------------------------------------------------------
// tb_eight_bit_three_to_one_arbiter_mux_module
//
// Directed scenarios followed by randomized traffic, all checked every cycle
// against a behavioural model: a cyclic search for the first requesting
// channel from the priority index, and a one-word output holding register.
// Build with MUX_FIXED_PRIORITY_EN defined to check the fixed-priority mode.
// ---------------------------------------------------------------------------
module tb_eight_bit_three_to_one_arbiter_mux_module;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] in1, in2, in3;
   logic       in1_valid, in2_valid, in3_valid;
   logic       in1_ready, in2_ready, in3_ready;
   logic [7:0] out;
   logic [1:0] sel;
   logic       out_valid;
   logic       out_ready;

   eight_bit_three_to_one_arbiter_mux_module #(.DATA_WIDTH(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .in1       (in1),
      .in2       (in2),
      .in3       (in3),
      .in1_valid (in1_valid),
      .in2_valid (in2_valid),
      .in3_valid (in3_valid),
      .in1_ready (in1_ready),
      .in2_ready (in2_ready),
      .in3_ready (in3_ready),
      .out       (out),
      .sel       (sel),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // stimulus sources
   logic [7:0] d [3];
   logic       v [3];

   // reference model state
   logic [7:0] m_out;
   int         m_sel;
   logic       m_ov;
   int         m_ptr;
   int         last_g;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_out = 8'h00;
      m_sel = 0;
      m_ov  = 1'b0;
      m_ptr = 0;
   endtask

   // Entered just after a falling edge; drives inputs, checks, clocks the
   // model across the rising edge, returns at the next falling edge.
   task automatic cycle();
      int         g;
      logic       can;
      logic [2:0] er;
      in1 = d[0]; in2 = d[1]; in3 = d[2];
      in1_valid = v[0]; in2_valid = v[1]; in3_valid = v[2];
      #1;
      can = !m_ov || out_ready;
      g = -1;
      if (!reset && can) begin
         for (int k = 0; k < 3; k++) begin
            int c;
            c = (m_ptr + k) % 3;
            if (g < 0 && v[c]) g = c;
         end
      end
      er = (g < 0) ? 3'b000 : (3'b001 << g);
      chk("ready", {29'd0, in3_ready, in2_ready, in1_ready}, {29'd0, er});
      chk("out", {24'd0, out}, {24'd0, m_out});
      chk("sel", {30'd0, sel}, m_sel);
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
      @(posedge clk);
      if (reset) begin
         model_reset();
      end else if (g >= 0) begin
         m_out = d[g];
         m_sel = g;
         m_ov  = 1'b1;
`ifndef MUX_FIXED_PRIORITY_EN
         m_ptr = (g + 1) % 3;
`endif
      end else if (out_ready) begin
         m_ov = 1'b0;
      end
      last_g = g;
      @(negedge clk);
   endtask

   initial begin
      int exp_sel [6];
`ifdef MUX_FIXED_PRIORITY_EN
      exp_sel = '{0, 0, 0, 0, 0, 0};
`else
      exp_sel = '{0, 1, 2, 0, 1, 2};
`endif
      last_g = -1;
      reset = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         v[c] = 1'b1;
         d[c] = 8'hF0 + 8'(c);
      end
      in1 = d[0]; in2 = d[1]; in3 = d[2];
      in1_valid = 1'b1; in2_valid = 1'b1; in3_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      model_reset();

      // reset held with all channels requesting
      for (int i = 0; i < 3; i++) cycle();
      chk("rst_out", {24'd0, out}, 32'h0);
      chk("rst_sel", {30'd0, sel}, 32'h0);
      chk("rst_ov", {31'd0, out_valid}, 32'h0);

      // fairness: all held valid, downstream always ready
      reset = 1'b0;
      d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33;
      for (int i = 0; i < 6; i++) begin
         cycle();
         chk("fair_sel", {30'd0, sel}, exp_sel[i]);
         chk("fair_out", {24'd0, out}, {24'd0, d[exp_sel[i]]});
         chk("fair_ov", {31'd0, out_valid}, 32'h1);
      end

      // single channel word
      v[0] = 1'b0; v[1] = 1'b0; v[2] = 1'b0;
      cycle();
      v[1] = 1'b1; d[1] = 8'hA5;
      cycle();
      chk("single_out", {24'd0, out}, 32'hA5);
      chk("single_sel", {30'd0, sel}, 32'h1);
      chk("single_ov", {31'd0, out_valid}, 32'h1);
      v[1] = 1'b0;
      cycle();
      chk("single_clear", {31'd0, out_valid}, 32'h0);
      chk("single_hold", {24'd0, out}, 32'hA5);

      // backpressure
      out_ready = 1'b0;
      v[2] = 1'b1; d[2] = 8'h5C;
      cycle();
      v[2] = 1'b0;
      v[0] = 1'b1; d[0] = 8'h77;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("bp_out", {24'd0, out}, 32'h5C);
         chk("bp_sel", {30'd0, sel}, 32'h2);
         chk("bp_in1_ready", {31'd0, in1_ready}, 32'h0);
      end
      out_ready = 1'b1;
      cycle();
      chk("bp_release_out", {24'd0, out}, 32'h77);
      chk("bp_release_sel", {30'd0, sel}, 32'h0);
      v[0] = 1'b0;
      cycle();

      // reset mid-stream with a word held (and ptr at PTR3 in round robin)
      out_ready = 1'b0;
      v[1] = 1'b1; d[1] = 8'h42;
      cycle();
      chk("mid_held", {31'd0, out_valid}, 32'h1);
      v[1] = 1'b0;
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      chk("mid_ov", {31'd0, out_valid}, 32'h0);
      out_ready = 1'b1;
      v[0] = 1'b1; v[1] = 1'b1; v[2] = 1'b1;
      d[0] = 8'h01; d[1] = 8'h02; d[2] = 8'h03;
      cycle();
      chk("mid_first", {30'd0, sel}, 32'h0);
      cycle();
      chk("mid_second", {30'd0, sel}, exp_sel[1]);

      // randomized traffic; sources hold each word until it is accepted
      for (int i = 0; i < 400; i++) begin
         if (last_g >= 0) v[last_g] = 1'b0;
         for (int c = 0; c < 3; c++) begin
            if (!v[c] && $urandom_range(0, 2) != 0) begin
               v[c] = 1'b1;
               d[c] = 8'($urandom);
            end
         end
         out_ready = ($urandom_range(0, 3) != 0);
         reset = ($urandom_range(0, 99) == 0);
         cycle();
      end
      reset = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
